uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver: next generation of the fixed 8-bit receiver, with configurable data width, parity mode and stop-bit count, majority-vote sampling, per-frame error flags and a receive FIFO with overrun detection. Sits between the pad-side `rx` line and the host logic. Consumes the 8x oversample tick from `baud_rate_en`. Presents frames through a first-word-fall-through `rx_rdy`/`rx_ack` handshake.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY`, "NONE": "NONE", "EVEN" or "ODD".
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: frames buffered, power of two, 2..16.
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `bd8_rate`  in  1  one-cycle tick at 8x the baud rate.
- `rx`  in  1  serial line, asynchronous, idle high.
- `rx_ack`  in  1  pop the head frame. Ignored when `rx_rdy`=0.
- `rx_data`  out  DATA_BITS  head frame data, LSB = first bit received.
- `rx_rdy`  out  1  FIFO not empty.
- `parity_err`  out  1  parity error flag of the head frame. 0 when PARITY="NONE".
- `frame_err`  out  1  framing error flag of the head frame.
- `overrun`  out  1  sticky. A frame was dropped because the FIFO was full.
- `busy`  out  1  receiver FSM is not in IDLE.

## Operation
- Input synchroniser: 2-flop synchroniser on `rx`, reset to 1. All logic uses the synchronised value `rxs`.
- Tick counter: 3-bit `phase` advances only on `bd8_rate`. One bit period is 8 ticks.
- Sampling: `rxs` is captured at phases 3, 4 and 5. The bit value is the 2-of-3 majority, decided at phase 5.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
- IDLE:
  - On the first tick with `rxs`=0, clear `phase` to 0 and enter START.
- START:
  - At the phase-5 decision, a majority of 1 is a false start: return to IDLE and write nothing.
  - A majority of 0 continues to DATA.
- DATA:
  - Shift in DATA_BITS bits, LSB first. A bit counter tracks progress.
  - When done, go to PAR if PARITY is not "NONE", otherwise go to STOP.
- PAR:
  - Expected parity is the XOR of the data bits, inverted for "ODD".
  - A mismatch sets the frame's `perr` bit.
- STOP:
  - Sample STOP_BITS stop bits. Any 0 sets the frame's `ferr` bit.
  - After the final stop decision, push {data, perr, ferr} into the FIFO.
  - Go to IDLE if the last stop bit was 1, otherwise go to WAIT_IDLE.
- WAIT_IDLE (break or line stuck low):
  - Stay until a tick sees `rxs`=1, then go to IDLE.
  - No further frames are written while the line stays low.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full.
  - A push to a full FIFO with no pop drops the new frame, sets `overrun`, and leaves the existing contents untouched.
  - `overrun` clears on the first accepted `rx_ack` after it was set.
- Data widths:
  - The FIFO entry is DATA_BITS+2 wide.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are decided by comparing the MSB.

## Timing
- Reset values:
  - `rx_data`=0, `rx_rdy`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - FSM in IDLE, FIFO empty, synchroniser flops at 1.
- `rst` asserted mid-frame aborts the frame. No partial frame is written. FIFO contents are discarded.
- Push occurs on the clock edge after the final stop-bit phase-5 decision.
- `rx_rdy` and the head outputs are valid one cycle after that push.
- `rx_ack` with `rx_rdy`=1 pops on that edge. The next entry, or `rx_rdy`=0, appears the following cycle.
- `busy` rises the cycle after start detection. It falls the cycle after the return to IDLE.
- `bd8_rate` held low freezes the FSM and `phase`. The FIFO handshake keeps running.

## Structure
- Shared definitions file `uart_defs`:
  - Parity mode constants.
  - FSM state encodings.
  - Sample phase constants (3/4/5).
  - These are reused by the matching transmitter.
- Sub-module `uart_rx_fifo`: synchronous first-word-fall-through FIFO, parametrised by WIDTH and DEPTH, with push/pop/full/empty.
- Top level contains the synchroniser, phase counter, majority voter, FSM and overrun flag.

## Test plan
- 8N1, frame for 0xAD, `rx_ack` tied high → one pop with `rx_data`=0xAD and both error flags 0. Follow with a back-to-back frame 0xAE, which must also be received correctly.
- PARITY="EVEN", DATA_BITS=7, send 0x35 with the parity bit inverted → `rx_data`=0x35, `parity_err`=1, `frame_err`=0. The same frame with correct parity → `parity_err`=0.
- Stop bit driven 0, then line held low for 30 ticks → one entry with `frame_err`=1 and FSM in WAIT_IDLE. No second entry. Return to IDLE after `rx` goes high.
- 2-tick low glitch on an idle line → no push, `busy` returns to 0, `rx_rdy` stays 0.
- FIFO_DEPTH=4, send 5 frames 0x01..0x05 with `rx_ack`=0 → `overrun`=1. Pops return 0x01..0x04 only. `overrun` clears on the first pop.
- `rst` pulsed during the DATA state of frame 0x5A → no entry. A clean 0x3C frame after release is received correctly.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: parity modes, receiver FSM states and the
// oversample phases at which the line is sampled. Reused by the transmitter.
package uart_defs;

    typedef enum logic [1:0] {
        ParNone,
        ParEven,
        ParOdd
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StWaitIdle
    } state_e;

    // Three samples around the bit centre; the vote is taken on the last one.
    localparam logic [2:0] SamplePh0 = 3'd3;
    localparam logic [2:0] SamplePh1 = 3'd4;
    localparam logic [2:0] SamplePh2 = 3'd5;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO. Head word is visible whenever
// the FIFO is non-empty and reads as zero when empty.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

    // A push into a full FIFO is accepted only if the head leaves on the same edge.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    assign o_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_rd_en) r_rd <= r_rd + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 8x oversample phase counter,
// 2-of-3 majority voter, frame FSM, receive FIFO and sticky overrun flag.
module uart_rx_param
    import uart_defs::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter string       PARITY     = "NONE",
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bd8_rate,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam parity_e     ParMode   = (PARITY == "EVEN") ? ParEven :
                                        (PARITY == "ODD")  ? ParOdd  : ParNone;
    localparam bit          HasParity = (ParMode != ParNone);
    localparam bit          OddParity = (ParMode == ParOdd);
    localparam int unsigned EntryW    = DATA_BITS + 2;
    localparam logic [3:0]  LastBit   = 4'(DATA_BITS - 1);
    localparam logic        LastStop  = 1'(STOP_BITS - 1);

    state_e               r_state;
    state_e               w_state_nx;
    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [2:0]           r_phase;
    logic [2:0]           w_phase_inc;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bitcnt;
    logic                 r_stopcnt;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_push;
    logic [EntryW-1:0]    r_push_data;
    logic                 r_overrun;
    logic                 w_in_frame;
    logic                 w_decide;
    logic                 w_maj;
    logic                 w_exp_par;
    logic                 w_start_det;
    logic                 w_frame_done;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [EntryW-1:0]    w_head;

    // Two-flop synchroniser on the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // The phase seen at a tick is the post-increment value, so the tick that
    // detects the start edge is phase 0 and the bit centre lands on phase 4.
    assign w_phase_inc  = r_phase + 3'd1;
    assign w_in_frame   = (r_state == StStart) || (r_state == StData) ||
                          (r_state == StPar)   || (r_state == StStop);
    assign w_decide     = bd8_rate && w_in_frame && (w_phase_inc == SamplePh2);
    assign w_maj        = maj3(r_s0, r_s1, r_rxs);
    assign w_exp_par    = (^r_shift) ^ OddParity;
    assign w_start_det  = bd8_rate && !r_rxs;
    assign w_frame_done = (r_state == StStop) && w_decide && (r_stopcnt == LastStop);

    // Next-state logic for the frame FSM.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            StIdle:     if (w_start_det) w_state_nx = StStart;
            StStart:    if (w_decide) w_state_nx = w_maj ? StIdle : StData;
            StData: begin
                if (w_decide && (r_bitcnt == LastBit)) begin
                    w_state_nx = HasParity ? StPar : StStop;
                end
            end
            StPar:      if (w_decide) w_state_nx = StStop;
            StStop:     if (w_frame_done) w_state_nx = w_maj ? StIdle : StWaitIdle;
            StWaitIdle: if (bd8_rate && r_rxs) w_state_nx = StIdle;
            default:    w_state_nx = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_nx;
    end

    // Phase counter, sample capture, shift register and per-frame error bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_stopcnt   <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            // Push lands one edge after the final stop decision.
            r_push <= w_frame_done;
            if (w_frame_done) r_push_data <= {r_shift, r_perr, r_ferr | ~w_maj};

            if (r_state == StIdle) begin
                if (w_start_det) begin
                    r_phase   <= '0;
                    r_bitcnt  <= '0;
                    r_stopcnt <= 1'b0;
                    r_perr    <= 1'b0;
                    r_ferr    <= 1'b0;
                end
            end else if (bd8_rate && w_in_frame) begin
                r_phase <= w_phase_inc;
                if (w_phase_inc == SamplePh0) r_s0 <= r_rxs;
                if (w_phase_inc == SamplePh1) r_s1 <= r_rxs;
                if (w_decide) begin
                    case (r_state)
                        StData: begin
                            r_shift  <= {w_maj, r_shift[DATA_BITS-1:1]};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                        StPar:   r_perr <= (w_maj != w_exp_par);
                        StStop: begin
                            if (!w_maj) r_ferr <= 1'b1;
                            r_stopcnt <= r_stopcnt + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign w_pop = rx_ack && !w_empty;

    uart_rx_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky overrun: set when a frame is dropped, cleared by the next accepted pop.
    always_ff @(posedge clk) begin
        if (rst)                               r_overrun <= 1'b0;
        else if (r_push && w_full && !w_pop)   r_overrun <= 1'b1;
        else if (w_pop)                        r_overrun <= 1'b0;
    end

    assign rx_data    = w_head[EntryW-1:2];
    assign parity_err = w_head[1];
    assign frame_err  = w_head[0];
    assign rx_rdy     = !w_empty;
    assign overrun    = r_overrun;
    assign busy       = (r_state != StIdle);

endmodule
